// File: rtl/t04_bus_handler.sv
// Single-master bus handler: serialises instruction fetches and data loads/stores
// onto a Wishbone-style bus, with a per-transaction timeout that aborts to a safe response.
module t04_bus_handler #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] final_address,
  input  logic [31:0] mem_store,
  input  logic [3:0]  mem_sel,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        halt,
  output logic        i_ack,
  output logic        d_ack,
  output logic [31:0] fetched_instr,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  // state | meaning
  // IDLE  | no transaction; latch a new request unless halt
  // BUS   | cyc/stb asserted, waiting for ack or timeout
  // RESP  | one-cycle completion pulse on i_ack or d_ack
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] to_cnt;
  logic       is_data;
  logic       is_load;
  logic       start;
  logic       acked;
  logic       timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (!halt) begin
          start     = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        // an ack on the final allowed cycle still wins over the abort
        if (wb_ack_i) begin
          acked     = 1'b1;
          state_nxt = RESP;
        end else if (to_cnt == TO_LAST) begin
          timed_out = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and bus drive; simultaneous read+write is a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'h0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      is_data  <= 1'b0;
      is_load  <= 1'b0;
      to_cnt   <= 8'h0;
    end else begin
      if (start) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= MemWrite;
        wb_sel_o <= (MemRead | MemWrite) ? mem_sel : 4'hF;
        wb_adr_o <= final_address;
        wb_dat_o <= mem_store;
        is_data  <= MemRead | MemWrite;
        is_load  <= MemRead & ~MemWrite;
        to_cnt   <= 8'h0;
      end else if (acked || timed_out) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end else if (state == BUS) begin
        to_cnt <= to_cnt + 8'h1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
    end else begin
      i_ack <= (acked || timed_out) && !is_data;
      d_ack <= (acked || timed_out) &&  is_data;
    end
  end

  // Timed-out fetches return a NOP so the core keeps running; timed-out loads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_instr <= 32'h0;
      load_data     <= 32'h0;
      bus_err       <= 1'b0;
    end else begin
      if (acked) begin
        if (!is_data)     fetched_instr <= wb_dat_i;
        else if (is_load) load_data     <= wb_dat_i;
      end else if (timed_out) begin
        bus_err <= 1'b1;
        if (!is_data)     fetched_instr <= NOP_INSTR;
        else if (is_load) load_data     <= 32'h0;
      end
    end
  end

endmodule
